// File: rtl/mem_pkg.sv
// Shared encodings for the sized data memory: access widths, FSM states and
// the alignment rule used to reject requests.
package mem_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } accessSize_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } memState_t;

  function automatic logic isMisaligned(input accessSize_t size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      SIZE_WORD: return off != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a memory word and extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [NUM_LANES-1:0][LANE_W-1:0] wordIn,
  input  logic [1:0]                       offset,
  input  accessSize_t                      size,
  input  logic                             unsignedLoad,
  output logic [31:0]                      data
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = wordIn[offset];
    halfSel = offset[1] ? {wordIn[3], wordIn[2]} : {wordIn[1], wordIn[0]};
    case (size)
      SIZE_BYTE: data = {{24{~unsignedLoad & byteSel[7]}}, byteSel};
      SIZE_HALF: data = {{16{~unsignedLoad & halfSel[15]}}, halfSel};
      default:   data = wordIn;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte/half/word addressable data memory with registered, extended loads and
// an optional zero-fill sweep after reset.
module sized_data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  AccessSize,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Busy,
  output logic        Misaligned
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH_WORDS];

  memState_t              state, stateNext;
  logic [IDX_W-1:0]       clrIdx, clrIdxNext;
  accessSize_t            size;
  logic [IDX_W-1:0]       idx;
  logic [1:0]             off;
  logic                   badAlign, doWrite, doRead, reject;
  logic [NUM_LANES-1:0]   laneEn;
  logic [NUM_LANES-1:0][LANE_W-1:0] storeData;
  logic [31:0]            alignedData;
  logic                   unusedAddr;

  assign size       = accessSize_t'(AccessSize);
  assign idx        = Address[IDX_W+1:2];
  assign off        = Address[1:0];
  // Upper address bits are deliberately dropped so the index wraps.
  assign unusedAddr = ^Address[31:IDX_W+2];

  assign Busy     = (state == ST_CLEAR);
  assign badAlign = isMisaligned(size, off);
  assign doWrite  = MemWrite && !Busy && !badAlign;
  assign doRead   = MemRead  && !Busy && !badAlign;
  assign reject   = (MemWrite || MemRead) && !Busy && badAlign;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] LANE = k[1:0];
    assign laneEn[k] = (size == SIZE_WORD)
                    || (size == SIZE_HALF && off[1] == LANE[1])
                    || (size == SIZE_BYTE && off == LANE);
  end

  // Narrow store data is replicated across lanes; laneEn picks the live ones.
  always_comb begin
    case (size)
      SIZE_BYTE: storeData = {NUM_LANES{WriteData[7:0]}};
      SIZE_HALF: storeData = {2{WriteData[15:0]}};
      default:   storeData = WriteData;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == ST_CLEAR) begin
        mem[clrIdx] <= '0;
      end else if (doWrite) begin
        for (int k = 0; k < NUM_LANES; k++)
          if (laneEn[k]) mem[idx][k] <= storeData[k];
      end
    end
  end

  load_align u_align (
    .wordIn       (mem[idx]),
    .offset       (off),
    .size         (size),
    .unsignedLoad (Unsigned),
    .data         (alignedData)
  );

  // The load samples the array before this edge's store: read-before-write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ReadData   <= '0;
      ReadValid  <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      ReadValid  <= doRead;
      Misaligned <= reject;
      if (doRead) ReadData <= alignedData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clrIdx <= '0;
    end else begin
      state  <= stateNext;
      clrIdx <= clrIdxNext;
    end
  end

  always_comb begin
    stateNext  = state;
    clrIdxNext = clrIdx;
    case (state)
      ST_CLEAR: begin
        clrIdxNext = clrIdx + 1'b1;
        if (&clrIdx) stateNext = ST_IDLE;
      end
      ST_IDLE: ;
    endcase
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// Directed stimulus with a queue-based scoreboard; a negedge monitor checks
// every ReadValid / Misaligned pulse against the queued expectation.
module tb_sized_data_memory;

  localparam int DEPTH = 1024;
  localparam int K_READ = 1, K_MIS = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Address = '0, WriteData = '0;
  logic        MemWrite = 1'b0, MemRead = 1'b0;
  logic [1:0]  AccessSize = 2'b10;
  logic        Unsigned = 1'b0;
  logic [31:0] ReadData;
  logic        ReadValid, Busy, Misaligned;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   compared = 0, mismatched = 0, cyc = 0;

  sized_data_memory #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .AccessSize(AccessSize),
    .Unsigned(Unsigned), .ReadData(ReadData), .ReadValid(ReadValid),
    .Busy(Busy), .Misaligned(Misaligned)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: each output pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (ReadValid || Misaligned) begin
      exp_t e;
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pulse: ReadValid=%0b Misaligned=%0b at cycle %0d with nothing pending",
                 ReadValid, Misaligned, cyc);
      end else begin
        e = q.pop_front();
        compared++;
        if ((e.kind == K_READ && !(ReadValid && !Misaligned)) ||
            (e.kind == K_MIS  && !(Misaligned && !ReadValid)) || e.cyc != cyc) begin
          mismatched++;
          $display("FAIL %s: got RV=%0b MA=%0b cycle %0d, expected kind %0d cycle %0d",
                   e.name, ReadValid, Misaligned, cyc, e.kind, e.cyc);
        end else if (e.kind == K_READ) begin
          check(e.name, ReadData, e.data);
        end
      end
    end
  end

  // Called at a negedge; leaves the request up for one rising edge.
  task automatic req(input string name, input logic [31:0] a, input logic [31:0] wd,
                     input logic w, input logic r, input logic [1:0] sz, input logic u,
                     input int kind, input logic [31:0] expData);
    exp_t e;
    Address = a; WriteData = wd; MemWrite = w; MemRead = r; AccessSize = sz; Unsigned = u;
    if (kind != 0) begin
      e.kind = kind; e.data = expData; e.cyc = cyc + 1; e.name = name;
      q.push_back(e);
    end
    @(negedge Clk);
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  // Counts Busy cycles starting at the negedge right after release.
  task automatic countBusy(input string name, input bit pokeDuringBusy);
    int cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (pokeDuringBusy && cnt == 500) begin
        Address = 32'h0; WriteData = 32'hDEADBEEF; AccessSize = 2'b10;
        MemWrite = 1'b1; MemRead = 1'b1;
      end else if (pokeDuringBusy && cnt == 501) begin
        Address = 32'h2; AccessSize = 2'b10; MemWrite = 1'b1; MemRead = 1'b0;
      end else begin
        MemWrite = 1'b0; MemRead = 1'b0;
      end
      if (!Busy) break;
      cnt++;
    end
    MemWrite = 1'b0; MemRead = 1'b0;
    check(name, cnt, DEPTH);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge Clk);
    check("reset_ReadData", ReadData, 32'h0);
    check("reset_ReadValid", {31'b0, ReadValid}, 32'h0);
    check("reset_Misaligned", {31'b0, Misaligned}, 32'h0);
    check("reset_Busy", {31'b0, Busy}, 32'h1);

    @(posedge Clk); #1 Reset = 1'b0;
    countBusy("busy_len_initial", 1'b0);
    check("idle_after_sweep", {31'b0, Busy}, 32'h0);

    req("lw_0x40_cleared", 32'h40, 0, 0, 1, 2'b10, 0, K_READ, 32'h0);
    req("lw_0x28_cleared", 32'h28, 0, 0, 1, 2'b10, 0, K_READ, 32'h0);

    req("sw_0x40", 32'h40, 32'h8899AABB, 1, 0, 2'b10, 0, 0, 0);
    req("lb_0x41", 32'h41, 0, 0, 1, 2'b00, 0, K_READ, 32'hFFFFFFAA);
    req("lbu_0x41", 32'h41, 0, 0, 1, 2'b00, 1, K_READ, 32'h000000AA);
    req("lh_0x42", 32'h42, 0, 0, 1, 2'b01, 0, K_READ, 32'hFFFF8899);
    req("lhu_0x42", 32'h42, 0, 0, 1, 2'b01, 1, K_READ, 32'h00008899);
    req("lb_0x40", 32'h40, 0, 0, 1, 2'b00, 0, K_READ, 32'hFFFFFFBB);
    req("lh_0x40", 32'h40, 0, 0, 1, 2'b01, 0, K_READ, 32'hFFFFAABB);
    req("lw_u_ignored", 32'h40, 0, 0, 1, 2'b10, 1, K_READ, 32'h8899AABB);

    req("sb_0x43", 32'h43, 32'hFFFFFF12, 1, 0, 2'b00, 0, 0, 0);
    req("lw_after_sb", 32'h40, 0, 0, 1, 2'b10, 0, K_READ, 32'h1299AABB);

    req("sw_misaligned", 32'h42, 32'h11223344, 1, 0, 2'b10, 0, K_MIS, 0);
    req("lw_unchanged", 32'h40, 0, 0, 1, 2'b10, 0, K_READ, 32'h1299AABB);
    req("lh_misaligned", 32'h41, 0, 0, 1, 2'b01, 0, K_MIS, 0);
    req("rsvd_size", 32'h40, 0, 0, 1, 2'b11, 0, K_MIS, 0);
    req("sh_misaligned", 32'h43, 32'hFFFF, 1, 0, 2'b01, 0, K_MIS, 0);
    req("lw_still_same", 32'h40, 0, 0, 1, 2'b10, 0, K_READ, 32'h1299AABB);

    req("sh_0x46", 32'h46, 32'h1234CAFE, 1, 0, 2'b01, 0, 0, 0);
    req("lw_0x44", 32'h44, 0, 0, 1, 2'b10, 0, K_READ, 32'hCAFE0000);
    req("lbu_0x47", 32'h47, 0, 0, 1, 2'b00, 1, K_READ, 32'h000000CA);

    req("sw_wrap", 32'h1000, 32'h5, 1, 0, 2'b10, 0, 0, 0);
    req("lw_wrap", 32'h0, 0, 0, 1, 2'b10, 0, K_READ, 32'h5);
    req("rw_same_edge", 32'h0, 32'h7, 1, 1, 2'b10, 0, K_READ, 32'h5);
    req("lw_after_rw", 32'h0, 0, 0, 1, 2'b10, 0, K_READ, 32'h7);
    repeat (3) @(negedge Clk);
    check("readdata_hold", ReadData, 32'h7);

    // Mid-sweep reset: restart at index 100, then poke while busy.
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    repeat (100) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    countBusy("busy_len_restart", 1'b1);
    req("lw_0_after_busy_poke", 32'h0, 0, 0, 1, 2'b10, 0, K_READ, 32'h0);
    req("lw_0x40_recleared", 32'h40, 0, 0, 1, 2'b10, 0, K_READ, 32'h0);

    repeat (4) @(negedge Clk);
    check("pending_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
